dsp_dot_sequencer: RTL
======================

// Module: dsp_dot_sequencer
// PURPOSE
//  Drives one DSP MAC slice (2-stage mult pipe + accumulator, ACC_EN sampled 2 cycles after EN-registered
//  operands) to compute signed dot products. Accepts operand pairs on a valid/ready stream with LAST,
//  generates EN/ACC_EN/clear for the DSP, drains the pipe, and returns each result on a valid/ready port.
//  Sits between the matrix-vector operand fetch and the result writer in PU_Matrix_vector.
// PARAMETERS
//  WIDTH_OP1  18  operand 1 width (signed)
//  WIDTH_OP2  18  operand 2 width (signed)
//  WIDTH_OUT  48  accumulator/result width (signed)
//  CNT_W      16  element counter width
// PORTS
//  CLK        in   1          clock
//  n_rst      in   1          synchronous reset, active-high
//  IN_VALID   in   1          operand pair valid
//  IN_READY   out  1          sequencer accepts pair (fire = IN_VALID & IN_READY)
//  IN_OP1     in   WIDTH_OP1  signed operand 1
//  IN_OP2     in   WIDTH_OP2  signed operand 2
//  IN_LAST    in   1          final pair of current vector
//  DSP_RSTN   out  1          DSP reset, active-low; = ~(n_rst | clr_pulse)
//  DSP_EN     out  1          DSP pipeline enable
//  DSP_ACC_EN out  1          DSP accumulate enable (fire delayed 2 cycles)
//  DSP_OP1    out  WIDTH_OP1  IN_OP1 when fire, else 0
//  DSP_OP2    out  WIDTH_OP2  IN_OP2 when fire, else 0
//  DSP_OUT    in   WIDTH_OUT  DSP accumulator output
//  RES_VALID  out  1          result valid
//  RES_READY  in   1          result consumer ready
//  RES_DATA   out  WIDTH_OUT  signed dot product
//  RES_LEN    out  CNT_W      number of pairs accumulated
//  BUSY       out  1          state != IDLE
// BEHAVIOUR
//  Reset (n_rst=1): state IDLE; IN_READY=0, DSP_EN=0, DSP_ACC_EN=0, fire delay pipe=0, RES_VALID=0,
//   RES_DATA=0, RES_LEN=0, BUSY=0, DSP_RSTN=0 (DSP cleared with us). Reset mid-vector drops it silently.
//  States: IDLE -> CLEAR -> RUN -> DRAIN -> (CAPTURE_WAIT) -> IDLE.
//   IDLE: IN_READY=0; IN_VALID=1 -> CLEAR (pair not consumed).
//   CLEAR: one cycle, clr_pulse=1 (DSP_RSTN=0) zeroes accumulator/pipe; cnt<=0; -> RUN.
//   RUN: IN_READY=1, DSP_EN=1. fire: cnt<=cnt+1 (wraps mod 2^CNT_W); fire & IN_LAST -> DRAIN, dcnt<=0.
//    Bubbles (IN_VALID=0): DSP_EN stays 1, zero operands injected, ACC_EN=0 in that slot -> no effect.
//   DRAIN: IN_READY=0, DSP_EN=1 for 3 cycles. LAST fired in cycle t: ACC_EN=1 in t+2, DSP_OUT final in t+3.
//    End of t+3: if RES_VALID=0 or RES_READY=1 -> RES_DATA<=DSP_OUT, RES_LEN<=cnt, RES_VALID<=1, -> IDLE;
//    else -> CAPTURE_WAIT.
//   CAPTURE_WAIT: DSP_EN=0 (DSP frozen, DSP_OUT stable); capture as above when RES_READY=1, -> IDLE.
//  DSP_ACC_EN = fire_d2 (2-stage shift of fire); shift advances only while DSP_EN=1.
//  Latency: LAST accepted in t -> RES_VALID=1 in t+4 (no backpressure). Per-vector overhead: 1 IDLE
//   + 1 CLEAR + 3 DRAIN cycles; throughput 1 pair/cycle in RUN.
//  Output: RES_VALID drops on RES_VALID&RES_READY unless a capture occurs same cycle (then stays 1, new data).
//   RES_DATA/RES_LEN stable while RES_VALID=1 & RES_READY=0.
//  Arithmetic: signed; accumulator wraps mod 2^WIDTH_OUT, no saturation, no overflow flag.
//  First pair with IN_LAST=1 is a length-1 vector. Empty vectors impossible (LAST rides on a pair).
// STRUCTURE
//  Package dsp_seq_pkg: state encoding localparams, ACC_DELAY=2, DRAIN_CYC=3.
//  Sub-module: none required; DSP instantiated by parent, connected via DSP_* ports.
//  Output register (RES_*) is a one-entry skid; fire delay pipe is a 2-bit shift reg.
// TESTING (bench instantiates DSP with default widths)
//  1 (1,2),(3,4),(5,6),(7,8)+LAST back-to-back -> RES_DATA=100, RES_LEN=4, RES_VALID 4 cycles after LAST.
//  2 Same pairs with IN_VALID low 2 cycles between each -> RES_DATA=100, RES_LEN=4; ACC_EN only 4 pulses.
//  3 Vector A as in 1, then (-3,5)+LAST -> results 100 then -15 (accumulator cleared between vectors).
//  4 RES_READY=0, two vectors (2,2)+LAST and (3,3)+LAST -> first 4 held stable; second waits in
//    CAPTURE_WAIT with DSP_EN=0; RES_READY=1 -> 4 then 9 delivered in order.
//  5 n_rst pulse after 2 pairs of a vector -> all outputs at reset values; next (6,7)+LAST -> 42, len 1.
//  6 (-131072,-131072)+LAST -> RES_DATA=17179869184, RES_LEN=1; (131071,-131072)x2 -> -34359476224.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// Shared constants for the DSP dot-product sequencer: FSM state encoding
// and the fixed timing of the attached MAC slice.
package dsp_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CAPW  = 3'd4;

  // Cycles from an operand pair entering the DSP to its product reaching the accumulator input
  localparam int ACC_DELAY = 2;
  // Enabled cycles after LAST is accepted until DSP_OUT holds the final sum
  localparam int DRAIN_CYC = 3;
  localparam int DCNT_W    = 2;

endpackage

// File: rtl/dsp_dot_sequencer.sv
// Sequencer driving one DSP MAC slice (2-stage multiplier + accumulator) to
// compute signed dot products from a valid/ready operand stream with LAST.
// It clears the DSP per vector, steers EN/ACC_EN, drains the multiplier pipe
// and hands each result to a one-entry output skid register.
module dsp_dot_sequencer #(
  parameter int WIDTH_OP1 = 18,
  parameter int WIDTH_OP2 = 18,
  parameter int WIDTH_OUT = 48,
  parameter int CNT_W     = 16
) (
  input  logic                        CLK,
  input  logic                        n_rst,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic signed [WIDTH_OP1-1:0] IN_OP1,
  input  logic signed [WIDTH_OP2-1:0] IN_OP2,
  input  logic                        IN_LAST,
  output logic                        DSP_RSTN,
  output logic                        DSP_EN,
  output logic                        DSP_ACC_EN,
  output logic signed [WIDTH_OP1-1:0] DSP_OP1,
  output logic signed [WIDTH_OP2-1:0] DSP_OP2,
  input  logic signed [WIDTH_OUT-1:0] DSP_OUT,
  output logic                        RES_VALID,
  input  logic                        RES_READY,
  output logic signed [WIDTH_OUT-1:0] RES_DATA,
  output logic        [CNT_W-1:0]     RES_LEN,
  output logic                        BUSY
);

  import dsp_seq_pkg::*;

  logic [2:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DCNT_W-1:0]           dcnt_q, dcnt_d;
  logic [ACC_DELAY-1:0]        fire_sr_q, fire_sr_d;
  logic                        res_valid_q, res_valid_d;
  logic signed [WIDTH_OUT-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0]            res_len_q, res_len_d;

  logic fire;
  logic clr_pulse;
  logic dsp_en;
  logic capture;

  assign IN_READY = (state_q == ST_RUN);
  assign fire     = IN_VALID & IN_READY;

  // Zero operands on non-fire slots so bubbles push nothing but zeros through the multiplier
  assign DSP_OP1    = fire ? IN_OP1 : '0;
  assign DSP_OP2    = fire ? IN_OP2 : '0;
  assign DSP_EN     = dsp_en;
  assign DSP_ACC_EN = fire_sr_q[ACC_DELAY-1];
  assign DSP_RSTN   = ~(n_rst | clr_pulse);
  assign BUSY       = (state_q != ST_IDLE);
  assign RES_VALID  = res_valid_q;
  assign RES_DATA   = res_data_q;
  assign RES_LEN    = res_len_q;

  // Next-state, counters and DSP control for the per-vector sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    clr_pulse = 1'b0;
    dsp_en    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The pending pair is left on the input; it is consumed once RUN is reached
        if (IN_VALID) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_pulse = 1'b1;
        cnt_d     = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        dsp_en = 1'b1;
        if (fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (IN_LAST) begin
            dcnt_d  = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        dsp_en = 1'b1;
        if (dcnt_q == DCNT_W'(DRAIN_CYC - 1)) begin
          if (!res_valid_q || RES_READY) begin
            capture = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CAPW;
          end
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      ST_CAPW: begin
        // DSP stays frozen so DSP_OUT holds the finished sum until the skid frees up
        if (RES_READY) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fire delay line aligning ACC_EN with the product leaving the multiplier pipe
  always_comb begin
    fire_sr_d = fire_sr_q;
    if (clr_pulse) begin
      fire_sr_d = '0;
    end else if (dsp_en) begin
      fire_sr_d = {fire_sr_q[ACC_DELAY-2:0], fire};
    end
  end

  // One-entry result skid: load on capture, release on consumer handshake
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_len_d   = res_len_q;
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = DSP_OUT;
      res_len_d   = cnt_q;
    end else if (RES_READY) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (n_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      fire_sr_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      fire_sr_q   <= fire_sr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_len_q   <= res_len_d;
    end
  end

endmodule
